// File: rtl/spi_gyro_responder_if.sv
// SPI bus between a gyro master and the responder (the target side).
interface spi_gyro_responder_if;
  logic cs;
  logic sclk;
  logic mosi;
  logic miso;

  modport master (output cs, output sclk, output mosi, input miso);
  modport slave  (input cs, input sclk, input mosi, output miso);
endinterface

// File: rtl/spi_gyro_responder.sv
// SPI mode-3 target emulating the 3-axis gyro register file.
// All SPI pins are oversampled in the clk domain; nothing runs on sclk.
module spi_gyro_responder #(
  parameter logic [7:0] WHO_AM_I_VAL = 8'hD3,
  parameter logic [7:0] CTRL1_RST    = 8'h07
) (
  input  logic                clk,
  input  logic                rst,
  spi_gyro_responder_if.slave spi,
  input  logic signed [15:0]  sample_x,
  input  logic signed [15:0]  sample_y,
  input  logic signed [15:0]  sample_z,
  output logic [7:0]          ctrl_reg1,
  output logic [7:0]          ctrl_reg2,
  output logic [7:0]          ctrl_reg3,
  output logic [7:0]          ctrl_reg4,
  output logic [7:0]          ctrl_reg5,
  output logic                wr_strobe,
  output logic [5:0]          wr_addr,
  output logic                frame_done
);

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} state_t;

  // synchronisers and edge-detect history
  logic cs_meta_q, cs_sync_q, cs_prev_q;
  logic cs_meta_d, cs_sync_d, cs_prev_d;
  logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic sclk_meta_d, sclk_sync_d, sclk_prev_d;
  logic mosi_meta_q, mosi_sync_q;
  logic mosi_meta_d, mosi_sync_d;

  logic cs_fall, cs_rise, sclk_rise, sclk_fall;

  // control state
  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       armed_q, armed_d;
  logic       miso_q, miso_d;
  logic       wr_strobe_q, wr_strobe_d;
  logic [5:0] wr_addr_q, wr_addr_d;
  logic       frame_done_q, frame_done_d;
  logic [7:0] ctrl_q [0:4];
  logic [7:0] ctrl_d [0:4];

  // datapath state
  logic [6:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic [5:0] addr_q, addr_d;
  logic       rw_q, rw_d;
  logic       ms_q, ms_d;
  logic [7:0] snap_q [0:5];
  logic [7:0] snap_d [0:5];

  logic [7:0] rx_byte;
  logic [5:0] rd_addr;
  logic [7:0] rd_data;

  // Two-flop synchroniser chains plus one history flop for edge detection
  always_comb begin
    cs_meta_d   = spi.cs;
    cs_sync_d   = cs_meta_q;
    cs_prev_d   = cs_sync_q;
    sclk_meta_d = spi.sclk;
    sclk_sync_d = sclk_meta_q;
    sclk_prev_d = sclk_sync_q;
    mosi_meta_d = spi.mosi;
    mosi_sync_d = mosi_meta_q;
  end

  assign cs_fall   =  cs_prev_q   & ~cs_sync_q;
  assign cs_rise   = ~cs_prev_q   &  cs_sync_q;
  assign sclk_rise = ~sclk_prev_q &  sclk_sync_q;
  assign sclk_fall =  sclk_prev_q & ~sclk_sync_q;

  // Byte being completed this cycle (valid on a rising sclk edge)
  assign rx_byte = {rx_q, mosi_sync_q};

  // Address to preload for a read: command address at end of the command
  // byte, otherwise the post-increment address for the next data byte
  always_comb begin
    rd_addr = addr_q + {5'd0, ms_q};
    if (state_q == ST_CMD) rd_addr = rx_byte[5:0];
  end

  // Register read map
  always_comb begin
    rd_data = 8'h00;
    case (rd_addr)
      6'h0F:   rd_data = WHO_AM_I_VAL;
      6'h20:   rd_data = ctrl_q[0];
      6'h21:   rd_data = ctrl_q[1];
      6'h22:   rd_data = ctrl_q[2];
      6'h23:   rd_data = ctrl_q[3];
      6'h24:   rd_data = ctrl_q[4];
      6'h28:   rd_data = snap_q[0];
      6'h29:   rd_data = snap_q[1];
      6'h2A:   rd_data = snap_q[2];
      6'h2B:   rd_data = snap_q[3];
      6'h2C:   rd_data = snap_q[4];
      6'h2D:   rd_data = snap_q[5];
      default: rd_data = 8'h00;
    endcase
  end

  // Frame FSM: command decode, shifting, write commit and read preload
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    armed_d      = armed_q | cs_sync_q;
    miso_d       = miso_q;
    wr_strobe_d  = 1'b0;
    wr_addr_d    = wr_addr_q;
    frame_done_d = 1'b0;
    ctrl_d       = ctrl_q;
    rx_d         = rx_q;
    tx_d         = tx_q;
    addr_d       = addr_q;
    rw_d         = rw_q;
    ms_d         = ms_q;
    snap_d       = snap_q;

    case (state_q)
      ST_IDLE: begin
        miso_d = 1'b0;
        // an unarmed responder ignores a frame already in progress at reset
        if (cs_fall && armed_q) begin
          state_d   = ST_CMD;
          bit_cnt_d = 3'd0;
          snap_d[0] = sample_x[7:0];
          snap_d[1] = sample_x[15:8];
          snap_d[2] = sample_y[7:0];
          snap_d[3] = sample_y[15:8];
          snap_d[4] = sample_z[7:0];
          snap_d[5] = sample_z[15:8];
        end
      end
      default: begin
        if (cs_rise) begin
          state_d      = ST_IDLE;
          miso_d       = 1'b0;
          frame_done_d = (state_q == ST_DATA);
        end else if (sclk_rise) begin
          rx_d      = rx_byte[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (state_q == ST_CMD) begin
              rw_d    = rx_byte[7];
              ms_d    = rx_byte[6];
              addr_d  = rx_byte[5:0];
              state_d = ST_DATA;
              if (rx_byte[7]) tx_d = rd_data;
            end else begin
              if (!rw_q) begin
                case (addr_q)
                  6'h20: ctrl_d[0] = rx_byte;
                  6'h21: ctrl_d[1] = rx_byte;
                  6'h22: ctrl_d[2] = rx_byte;
                  6'h23: ctrl_d[3] = rx_byte;
                  6'h24: ctrl_d[4] = rx_byte;
                  default: ;
                endcase
                if (addr_q >= 6'h20 && addr_q <= 6'h24) begin
                  wr_strobe_d = 1'b1;
                  wr_addr_d   = addr_q;
                end
              end
              addr_d = addr_q + {5'd0, ms_q};
              if (rw_q) tx_d = rd_data;
            end
          end
        end else if (sclk_fall) begin
          miso_d = 1'b0;
          if (state_q == ST_DATA && rw_q) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end
        end
      end
    endcase
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_meta_q    <= 1'b0;
      cs_sync_q    <= 1'b0;
      cs_prev_q    <= 1'b0;
      sclk_meta_q  <= 1'b1;
      sclk_sync_q  <= 1'b1;
      sclk_prev_q  <= 1'b1;
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd0;
      armed_q      <= 1'b0;
      miso_q       <= 1'b0;
      wr_strobe_q  <= 1'b0;
      wr_addr_q    <= 6'd0;
      frame_done_q <= 1'b0;
      ctrl_q[0]    <= CTRL1_RST;
      ctrl_q[1]    <= 8'h00;
      ctrl_q[2]    <= 8'h00;
      ctrl_q[3]    <= 8'h00;
      ctrl_q[4]    <= 8'h00;
    end else begin
      cs_meta_q    <= cs_meta_d;
      cs_sync_q    <= cs_sync_d;
      cs_prev_q    <= cs_prev_d;
      sclk_meta_q  <= sclk_meta_d;
      sclk_sync_q  <= sclk_sync_d;
      sclk_prev_q  <= sclk_prev_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      armed_q      <= armed_d;
      miso_q       <= miso_d;
      wr_strobe_q  <= wr_strobe_d;
      wr_addr_q    <= wr_addr_d;
      frame_done_q <= frame_done_d;
      ctrl_q       <= ctrl_d;
    end
  end

  // Datapath registers, no reset
  always_ff @(posedge clk) begin
    mosi_meta_q <= mosi_meta_d;
    mosi_sync_q <= mosi_sync_d;
    rx_q        <= rx_d;
    tx_q        <= tx_d;
    addr_q      <= addr_d;
    rw_q        <= rw_d;
    ms_q        <= ms_d;
    snap_q      <= snap_d;
  end

  assign spi.miso   = miso_q;
  assign ctrl_reg1  = ctrl_q[0];
  assign ctrl_reg2  = ctrl_q[1];
  assign ctrl_reg3  = ctrl_q[2];
  assign ctrl_reg4  = ctrl_q[3];
  assign ctrl_reg5  = ctrl_q[4];
  assign wr_strobe  = wr_strobe_q;
  assign wr_addr    = wr_addr_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_spi_gyro_responder.sv
// Directed bench for spi_gyro_responder: table of two-byte frames plus
// hand-written multi-byte, partial-byte and mid-frame-reset sequences.
module tb_spi_gyro_responder;

  localparam int HALF = 8;  // clk cycles per sclk half period

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [15:0] sample_x = '0, sample_y = '0, sample_z = '0;
  logic [7:0] ctrl_reg1, ctrl_reg2, ctrl_reg3, ctrl_reg4, ctrl_reg5;
  logic       wr_strobe, frame_done;
  logic [5:0] wr_addr;

  spi_gyro_responder_if spi_bus ();

  spi_gyro_responder dut (
    .clk(clk), .rst(rst), .spi(spi_bus),
    .sample_x(sample_x), .sample_y(sample_y), .sample_z(sample_z),
    .ctrl_reg1(ctrl_reg1), .ctrl_reg2(ctrl_reg2), .ctrl_reg3(ctrl_reg3),
    .ctrl_reg4(ctrl_reg4), .ctrl_reg5(ctrl_reg5),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  int strobe_cnt = 0;
  int done_cnt   = 0;
  logic [5:0] last_waddr = '0;

  // Count output pulses away from the active edge
  always @(negedge clk) begin
    if (wr_strobe) begin
      strobe_cnt <= strobe_cnt + 1;
      last_waddr <= wr_addr;
    end
    if (frame_done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic cs_low();
    spi_bus.cs = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_high();
    wait_clk(HALF);
    spi_bus.cs = 1'b1;
    wait_clk(12);
  endtask

  // Mode 3: drive mosi at the falling edge, sample miso just before the rising edge
  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_bus.sclk = 1'b0;
      spi_bus.mosi = tx[i];
      wait_clk(HALF);
      rx = {rx[6:0], spi_bus.miso};
      spi_bus.sclk = 1'b1;
      wait_clk(HALF);
    end
  endtask

  typedef struct {
    string      name;
    logic [7:0] cmd;
    logic [7:0] data;
    logic [7:0] exp_miso;
    int         exp_strobes;
    logic [5:0] exp_waddr;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [7:0] rc, rd;
    logic [7:0] exp_burst [6];
    int s0, f0;

    vecs[0] = '{"wr20", 8'h20, 8'h0F, 8'h00, 1, 6'h20};
    vecs[1] = '{"wr21", 8'h21, 8'h00, 8'h00, 1, 6'h21};
    vecs[2] = '{"wr24", 8'h24, 8'h10, 8'h00, 1, 6'h24};
    vecs[3] = '{"rd0F", 8'h8F, 8'h00, 8'hD3, 0, 6'h00};
    vecs[4] = '{"rd00", 8'h80, 8'h00, 8'h00, 0, 6'h00};
    vecs[5] = '{"rd20", 8'hA0, 8'h00, 8'h0F, 0, 6'h00};
    vecs[6] = '{"wr10_drop", 8'h10, 8'h55, 8'h00, 0, 6'h00};
    vecs[7] = '{"rd24", 8'hA4, 8'h00, 8'h10, 0, 6'h00};
    vecs[8] = '{"wr23", 8'h23, 8'h5A, 8'h00, 1, 6'h23};
    vecs[9] = '{"rd23", 8'hA3, 8'hFF, 8'h5A, 0, 6'h00};

    spi_bus.cs = 1'b1; spi_bus.sclk = 1'b1; spi_bus.mosi = 1'b0;
    wait_clk(5);
    rst = 1'b0;
    wait_clk(20);

    // reset state
    check("rst_ctrl1", ctrl_reg1, 8'h07);
    check("rst_ctrl2", ctrl_reg2, 8'h00);
    check("rst_ctrl3", ctrl_reg3, 8'h00);
    check("rst_ctrl4", ctrl_reg4, 8'h00);
    check("rst_ctrl5", ctrl_reg5, 8'h00);
    check("rst_miso", spi_bus.miso, 1'b0);
    check("rst_strobes", strobe_cnt, 0);
    check("rst_frame_done", done_cnt, 0);

    // table of two-byte frames
    for (int k = 0; k < 10; k++) begin
      s0 = strobe_cnt; f0 = done_cnt;
      cs_low();
      xfer(vecs[k].cmd, 8, rc);
      xfer(vecs[k].data, 8, rd);
      cs_high();
      check({vecs[k].name, "_cmd_miso"}, rc, 8'h00);
      check({vecs[k].name, "_data_miso"}, rd, vecs[k].exp_miso);
      check({vecs[k].name, "_strobes"}, strobe_cnt - s0, vecs[k].exp_strobes);
      if (vecs[k].exp_strobes > 0) check({vecs[k].name, "_waddr"}, last_waddr, vecs[k].exp_waddr);
      check({vecs[k].name, "_frame_done"}, done_cnt - f0, 1);
    end
    check("ctrl1_after", ctrl_reg1, 8'h0F);
    check("ctrl2_after", ctrl_reg2, 8'h00);
    check("ctrl4_after", ctrl_reg4, 8'h5A);
    check("ctrl5_after", ctrl_reg5, 8'h10);

    // burst read of the sample snapshot; samples change mid-frame
    sample_x = 16'h1234; sample_y = 16'hABCD; sample_z = 16'h8001;
    exp_burst = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'h01, 8'h80};
    cs_low();
    xfer(8'hE8, 8, rc);
    for (int b = 0; b < 6; b++) begin
      xfer(8'h00, 8, rd);
      check($sformatf("burst_byte%0d", b), rd, exp_burst[b]);
      if (b == 0) begin
        sample_x = 16'h5555; sample_y = 16'h6666; sample_z = 16'h7777;
      end
    end
    cs_high();

    // auto-increment wrap 0x3F -> 0x00
    cs_low();
    xfer(8'hFF, 8, rc);
    xfer(8'h00, 8, rd); check("wrap_3F", rd, 8'h00);
    xfer(8'h00, 8, rd); check("wrap_00", rd, 8'h00);
    cs_high();
    cs_low();
    xfer(8'hCF, 8, rc);
    xfer(8'h00, 8, rd); check("inc_0F", rd, 8'hD3);
    xfer(8'h00, 8, rd); check("inc_10", rd, 8'h00);
    cs_high();

    // partial command byte: no frame_done, no strobe
    s0 = strobe_cnt; f0 = done_cnt;
    cs_low();
    xfer(8'h22, 4, rc);
    cs_high();
    check("partcmd_frame_done", done_cnt - f0, 0);
    check("partcmd_strobes", strobe_cnt - s0, 0);

    // partial data byte: discarded, but command completed
    s0 = strobe_cnt; f0 = done_cnt;
    cs_low();
    xfer(8'h22, 8, rc);
    xfer(8'h99, 4, rd);
    cs_high();
    check("partdata_ctrl3", ctrl_reg3, 8'h00);
    check("partdata_strobes", strobe_cnt - s0, 0);
    check("partdata_frame_done", done_cnt - f0, 1);

    // reset in the middle of a write frame: rest of frame ignored
    s0 = strobe_cnt; f0 = done_cnt;
    cs_low();
    xfer(8'h22, 8, rc);
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(2);
    xfer(8'hAA, 8, rd);
    xfer(8'hBB, 8, rd);
    cs_high();
    check("midrst_strobes", strobe_cnt - s0, 0);
    check("midrst_frame_done", done_cnt - f0, 0);
    check("midrst_ctrl3", ctrl_reg3, 8'h00);
    check("midrst_ctrl1", ctrl_reg1, 8'h07);
    check("midrst_ctrl4", ctrl_reg4, 8'h00);

    // next frame decodes normally
    s0 = strobe_cnt;
    cs_low();
    xfer(8'h22, 8, rc);
    xfer(8'h77, 8, rd);
    cs_high();
    check("postrst_ctrl3", ctrl_reg3, 8'h77);
    check("postrst_strobes", strobe_cnt - s0, 1);
    check("postrst_waddr", last_waddr, 6'h22);
    cs_low();
    xfer(8'hA2, 8, rc);
    xfer(8'h00, 8, rd);
    cs_high();
    check("postrst_rd22", rd, 8'h77);
    check("idle_miso", spi_bus.miso, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
